// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle datapath: divided clock-enable, restart
// sequencing, single-step, PC breakpoint and instruction-budget halting.
module cpu_run_ctrl #(
  parameter int PC_WIDTH  = 16,
  parameter int DIV_WIDTH = 27,
  parameter int CNT_WIDTH = 32,
  parameter int RST_HOLD  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Restart_btn,
  input  logic                 Step_btn,
  input  logic                 Mode,
  input  logic [DIV_WIDTH-1:0] Div_ratio,
  input  logic                 Bp_en,
  input  logic [PC_WIDTH-1:0]  Bp_addr,
  input  logic [CNT_WIDTH-1:0] Max_cycles,
  input  logic [PC_WIDTH-1:0]  PC,
  output logic                 Cpu_en,
  output logic                 Cpu_restart,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] Cycle_count,
  output logic [1:0]           State
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RESTART = 2'b01,
    ST_RUN     = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 cpu_en_q, cpu_en_d;
  logic                 restart_out_q, restart_out_d;
  logic                 halted_q, halted_d;
  logic                 rst_meta_q, rst_meta_d, rst_sync_q, rst_sync_d, rst_prev_q, rst_prev_d;
  logic                 stp_meta_q, stp_meta_d, stp_sync_q, stp_sync_d, stp_prev_q, stp_prev_d;

  logic                 restart_ev, step_ev, tick, budget_hit, bp_hit;
  logic [CNT_WIDTH-1:0] count_inc;

  always_comb begin
    rst_meta_d    = Restart_btn;
    rst_sync_d    = rst_meta_q;
    rst_prev_d    = rst_sync_q;
    stp_meta_d    = Step_btn;
    stp_sync_d    = stp_meta_q;
    stp_prev_d    = stp_sync_q;
    state_d       = state_q;
    hold_d        = hold_q;
    div_d         = div_q;
    count_d       = count_q;
    cpu_en_d      = 1'b0;
    tick          = 1'b0;

    restart_ev = rst_sync_q & ~rst_prev_q;
    step_ev    = stp_sync_q & ~stp_prev_q;
    budget_hit = (Max_cycles != '0) && (count_q == Max_cycles);
    bp_hit     = Bp_en && (PC == Bp_addr);
    count_inc  = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);

    // A restart event overrides whatever tick or step coincides with it.
    if (restart_ev) begin
      state_d = ST_RESTART;
      hold_d  = '0;
      div_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RESTART: begin
          div_d = '0;
          if (hold_q == HOLD_LAST) state_d = ST_RUN;
          else                     hold_d  = hold_q + HOLD_W'(1);
        end
        ST_RUN: begin
          if (!Mode) begin
            // >= so that lowering Div_ratio mid-count reloads instead of wrapping
            tick  = (div_q >= Div_ratio);
            div_d = tick ? '0 : div_q + DIV_WIDTH'(1);
          end else begin
            tick = step_ev;
          end
          if (tick) begin
            if (bp_hit || budget_hit) begin
              state_d = ST_HALT;
            end else begin
              cpu_en_d = 1'b1;
              count_d  = count_inc;
            end
          end
        end
        ST_HALT: begin
          // Stepping out of HALT deliberately skips the breakpoint compare.
          if (step_ev && !budget_hit) begin
            cpu_en_d = 1'b1;
            count_d  = count_inc;
            div_d    = '0;
            state_d  = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    restart_out_d = (state_d == ST_RESTART);
    halted_d      = (state_d == ST_HALT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      div_q         <= '0;
      count_q       <= '0;
      cpu_en_q      <= 1'b0;
      restart_out_q <= 1'b0;
      halted_q      <= 1'b0;
      rst_meta_q    <= 1'b0;
      rst_sync_q    <= 1'b0;
      rst_prev_q    <= 1'b0;
      stp_meta_q    <= 1'b0;
      stp_sync_q    <= 1'b0;
      stp_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      div_q         <= div_d;
      count_q       <= count_d;
      cpu_en_q      <= cpu_en_d;
      restart_out_q <= restart_out_d;
      halted_q      <= halted_d;
      rst_meta_q    <= rst_meta_d;
      rst_sync_q    <= rst_sync_d;
      rst_prev_q    <= rst_prev_d;
      stp_meta_q    <= stp_meta_d;
      stp_sync_q    <= stp_sync_d;
      stp_prev_q    <= stp_prev_d;
    end
  end

  assign Cpu_en      = cpu_en_q;
  assign Cpu_restart = restart_out_q;
  assign Halted      = halted_q;
  assign Cycle_count = count_q;
  assign State       = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl; expected Cycle_count values of each
// Cpu_en pulse are queued when stimulus is applied and popped on each pulse.
module tb_cpu_run_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Restart_btn = 1'b0;
  logic        Step_btn = 1'b0;
  logic        Mode = 1'b0;
  logic [26:0] Div_ratio = '0;
  logic        Bp_en = 1'b0;
  logic [15:0] Bp_addr = '0;
  logic [31:0] Max_cycles = '0;
  logic [15:0] PC;
  logic        Cpu_en, Cpu_restart, Halted;
  logic [31:0] Cycle_count;
  logic [1:0]  State;

  logic        pc_follow = 1'b0;
  logic [15:0] pc_manual = '0;

  int errors = 0;
  int checks = 0;
  int unsigned exp_q[$];

  assign PC = pc_follow ? {Cycle_count[14:0], 1'b0} : pc_manual;

  always #5 Clk = ~Clk;

  cpu_run_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Restart_btn(Restart_btn), .Step_btn(Step_btn),
    .Mode(Mode), .Div_ratio(Div_ratio), .Bp_en(Bp_en), .Bp_addr(Bp_addr),
    .Max_cycles(Max_cycles), .PC(PC), .Cpu_en(Cpu_en), .Cpu_restart(Cpu_restart),
    .Halted(Halted), .Cycle_count(Cycle_count), .State(State)
  );

  task automatic step_clk();
    @(posedge Clk);
    #1;
  endtask

  // Presses Restart_btn and returns #1 after the first edge that lands in RUN.
  task automatic do_restart(output bit ok);
    bit seen = 0;
    ok = 0;
    Restart_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step_clk();
      if (Cpu_restart) seen = 1;
      if (seen && State == 2'b10) begin ok = 1; break; end
    end
    Restart_btn = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step_clk(); step_clk();
    checks++; if (State !== 2'b00) begin errors++; $display("[TB] FAIL reset_state: got %0b expected 00", State); end
    checks++; if (Cpu_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_en: got %0b expected 0", Cpu_en); end
    checks++; if (Cpu_restart !== 1'b0) begin errors++; $display("[TB] FAIL reset_restart: got %0b expected 0", Cpu_restart); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %0b expected 0", Halted); end
    checks++; if (Cycle_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", Cycle_count); end
    Reset = 1'b0;
  endtask

  task automatic test_restart_seq();
    int lat = 0;
    int hi = 1;
    Mode = 1'b1;
    Restart_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_clk(); lat++;
      if (Cpu_restart === 1'b1) break;
    end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL restart_latency: got %0d expected 3", lat); end
    checks++; if (State !== 2'b01) begin errors++; $display("[TB] FAIL restart_state: got %0b expected 01", State); end
    for (int i = 0; i < 20; i++) begin
      step_clk();
      if (Cpu_restart !== 1'b1) break;
      hi++;
    end
    checks++; if (hi != 4) begin errors++; $display("[TB] FAIL restart_hold: got %0d expected 4", hi); end
    checks++; if (State !== 2'b10) begin errors++; $display("[TB] FAIL restart_to_run: got %0b expected 10", State); end
    checks++; if (Cycle_count !== 32'd0) begin errors++; $display("[TB] FAIL restart_count: got %0d expected 0", Cycle_count); end
    repeat (10) step_clk();
    checks++; if (State !== 2'b10 || Cpu_restart !== 1'b0) begin
      errors++; $display("[TB] FAIL restart_held_once: got state %0b restart %0b expected 10 0", State, Cpu_restart);
    end
    Restart_btn = 1'b0;
    repeat (3) step_clk();
  endtask

  task automatic test_free_run();
    bit ok;
    bit exp_en;
    Mode = 1'b0; Div_ratio = 27'd3; Max_cycles = '0; Bp_en = 1'b0;
    exp_q.delete();
    do_restart(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL free_restart: got timeout expected RUN"); end
    for (int i = 1; i <= 40; i++) begin
      exp_en = (i % 4 == 0);
      if (exp_en) exp_q.push_back(i / 4);
      step_clk();
      checks++; if (Cpu_en !== exp_en) begin errors++; $display("[TB] FAIL free_pulse_%0d: got %0b expected %0b", i, Cpu_en, exp_en); end
      if (Cpu_en === 1'b1 && exp_q.size() > 0) begin
        int unsigned e = exp_q.pop_front();
        checks++; if (Cycle_count !== e) begin errors++; $display("[TB] FAIL free_count: got %0d expected %0d", Cycle_count, e); end
      end
    end
    checks++; if (Cycle_count !== 32'd10) begin errors++; $display("[TB] FAIL free_total: got %0d expected 10", Cycle_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL free_missing: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_breakpoint();
    bit ok;
    bit seen_halt = 0;
    Mode = 1'b0; Div_ratio = 27'd0; Bp_addr = 16'h0006; Bp_en = 1'b1; pc_follow = 1'b1;
    exp_q.delete();
    do_restart(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_restart: got timeout expected RUN"); end
    for (int unsigned k = 1; k <= 3; k++) exp_q.push_back(k);
    for (int i = 0; i < 10; i++) begin
      step_clk();
      if (Cpu_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL bp_extra_pulse: got count %0d expected none", Cycle_count);
        end else begin
          int unsigned e = exp_q.pop_front();
          checks++; if (Cycle_count !== e) begin errors++; $display("[TB] FAIL bp_count: got %0d expected %0d", Cycle_count, e); end
        end
      end
      if (Halted === 1'b1) begin seen_halt = 1; break; end
    end
    checks++; if (!seen_halt) begin errors++; $display("[TB] FAIL bp_halt: got no halt expected halt"); end
    checks++; if (Cycle_count !== 32'd3) begin errors++; $display("[TB] FAIL bp_halt_count: got %0d expected 3", Cycle_count); end
    checks++; if (State !== 2'b11) begin errors++; $display("[TB] FAIL bp_halt_state: got %0b expected 11", State); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL bp_missing: got %0d pending expected 0", exp_q.size()); end
    Step_btn = 1'b1;
    step_clk(); step_clk();
    checks++; if (Cpu_en !== 1'b0 || Halted !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_step_early: got en %0b halted %0b expected 0 1", Cpu_en, Halted);
    end
    step_clk();
    checks++; if (Cpu_en !== 1'b1) begin errors++; $display("[TB] FAIL bp_step_pulse: got %0b expected 1", Cpu_en); end
    checks++; if (Cycle_count !== 32'd4) begin errors++; $display("[TB] FAIL bp_step_count: got %0d expected 4", Cycle_count); end
    checks++; if (State !== 2'b10 || Halted !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_step_run: got state %0b halted %0b expected 10 0", State, Halted);
    end
    step_clk();
    checks++; if (Cpu_en !== 1'b1 || Cycle_count !== 32'd5) begin
      errors++; $display("[TB] FAIL bp_resume: got en %0b count %0d expected 1 5", Cpu_en, Cycle_count);
    end
    Step_btn = 1'b0; Bp_en = 1'b0; pc_follow = 1'b0;
  endtask

  task automatic test_single_step();
    bit ok;
    bit exp_en;
    Mode = 1'b1; Max_cycles = '0; Bp_en = 1'b0;
    exp_q.delete();
    do_restart(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL step_restart: got timeout expected RUN"); end
    for (int p = 0; p < 5; p++) begin
      exp_q.push_back(p + 1);
      Step_btn = 1'b1;
      for (int j = 1; j <= 20; j++) begin
        if (j == 11) Step_btn = 1'b0;
        exp_en = (j == 3);
        step_clk();
        checks++; if (Cpu_en !== exp_en) begin errors++; $display("[TB] FAIL step_pulse_%0d_%0d: got %0b expected %0b", p, j, Cpu_en, exp_en); end
        if (Cpu_en === 1'b1 && exp_q.size() > 0) begin
          int unsigned e = exp_q.pop_front();
          checks++; if (Cycle_count !== e) begin errors++; $display("[TB] FAIL step_count: got %0d expected %0d", Cycle_count, e); end
        end
      end
    end
    checks++; if (Cycle_count !== 32'd5) begin errors++; $display("[TB] FAIL step_total: got %0d expected 5", Cycle_count); end
  endtask

  task automatic test_budget();
    bit ok;
    bit seen_halt = 0;
    int extra = 0;
    Mode = 1'b0; Div_ratio = 27'd1; Max_cycles = 32'd20; Bp_en = 1'b0;
    exp_q.delete();
    do_restart(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL budget_restart: got timeout expected RUN"); end
    for (int unsigned k = 1; k <= 20; k++) exp_q.push_back(k);
    for (int i = 0; i < 80; i++) begin
      step_clk();
      if (Cpu_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL budget_extra_pulse: got count %0d expected none", Cycle_count);
        end else begin
          int unsigned e = exp_q.pop_front();
          checks++; if (Cycle_count !== e) begin errors++; $display("[TB] FAIL budget_count: got %0d expected %0d", Cycle_count, e); end
        end
      end
      if (Halted === 1'b1) begin seen_halt = 1; break; end
    end
    checks++; if (!seen_halt) begin errors++; $display("[TB] FAIL budget_halt: got no halt expected halt"); end
    checks++; if (Cycle_count !== 32'd20) begin errors++; $display("[TB] FAIL budget_total: got %0d expected 20", Cycle_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL budget_missing: got %0d pending expected 0", exp_q.size()); end
    repeat (10) begin step_clk(); if (Cpu_en === 1'b1) extra++; end
    Step_btn = 1'b1;
    repeat (6) begin step_clk(); if (Cpu_en === 1'b1) extra++; end
    checks++; if (extra != 0) begin errors++; $display("[TB] FAIL budget_no_pulse: got %0d pulses expected 0", extra); end
    checks++; if (State !== 2'b11 || Cycle_count !== 32'd20) begin
      errors++; $display("[TB] FAIL budget_step_stays: got state %0b count %0d expected 11 20", State, Cycle_count);
    end
    Step_btn = 1'b0; Max_cycles = '0;
    repeat (3) step_clk();
  endtask

  task automatic test_restart_vs_tick();
    bit ok;
    Mode = 1'b0; Div_ratio = 27'd3; Max_cycles = '0;
    do_restart(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rvt_restart: got timeout expected RUN"); end
    repeat (5) step_clk();
    checks++; if (Cycle_count !== 32'd1) begin errors++; $display("[TB] FAIL rvt_pre_count: got %0d expected 1", Cycle_count); end
    Restart_btn = 1'b1;
    step_clk(); step_clk(); step_clk();
    checks++; if (Cpu_en !== 1'b0) begin errors++; $display("[TB] FAIL rvt_no_pulse: got %0b expected 0", Cpu_en); end
    checks++; if (State !== 2'b01 || Cpu_restart !== 1'b1) begin
      errors++; $display("[TB] FAIL rvt_restart_state: got state %0b restart %0b expected 01 1", State, Cpu_restart);
    end
    checks++; if (Cycle_count !== 32'd0) begin errors++; $display("[TB] FAIL rvt_count: got %0d expected 0", Cycle_count); end
    step_clk();
    Reset = 1'b1;
    step_clk();
    checks++; if (State !== 2'b00 || Cpu_restart !== 1'b0 || Cpu_en !== 1'b0) begin
      errors++; $display("[TB] FAIL rvt_reset: got state %0b restart %0b en %0b expected 00 0 0", State, Cpu_restart, Cpu_en);
    end
    checks++; if (Cycle_count !== 32'd0) begin errors++; $display("[TB] FAIL rvt_reset_count: got %0d expected 0", Cycle_count); end
    Reset = 1'b0; Restart_btn = 1'b0;
    repeat (6) step_clk();
    checks++; if (State !== 2'b00) begin errors++; $display("[TB] FAIL rvt_idle: got %0b expected 00", State); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_restart_seq();
    test_free_run();
    test_breakpoint();
    test_single_step();
    test_budget();
    test_restart_vs_tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Parametrised run controller for the 16-bit single-cycle datapath and its wider successors. It replaces fixed reset timing, a free-running slow clock and a fixed stop time with a managed execution flow. The block generates a one-Clk-wide CPU clock-enable at a programmable divide ratio, sequences the CPU restart pulse, and supports single-step, PC breakpoint and cycle-budget halting. It sits between the board buttons/switches and the datapath's Restart/enable inputs, all in one clock domain.

Parameters:
PC_WIDTH, 16, width of observed PC and breakpoint address
DIV_WIDTH, 27, width of divide-ratio counter (100 MHz to 1 Hz needs 27)
CNT_WIDTH, 32, width of executed-instruction counter and cycle budget
RST_HOLD, 4, Clk cycles Cpu_restart is held high (>=1)

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high; clears all state
Restart_btn  input  1  raw button, asynchronous; rising edge requests CPU restart
Step_btn  input  1  raw button, asynchronous; rising edge requests one instruction
Mode  input  1  0 = free run, 1 = single-step
Div_ratio  input  DIV_WIDTH  enable pulse period minus 1, in Clk cycles
Bp_en  input  1  breakpoint enable
Bp_addr  input  PC_WIDTH  breakpoint PC
Max_cycles  input  CNT_WIDTH  instruction budget; 0 = unlimited
PC  input  PC_WIDTH  current PC from datapath
Cpu_en  output  1  one-Clk pulse; datapath advances one instruction when high
Cpu_restart  output  1  active-high restart to datapath PC/program state
Halted  output  1  high in HALT state
Cycle_count  output  CNT_WIDTH  instructions executed since last restart
State  output  2  00 IDLE, 01 RESTART, 10 RUN, 11 HALT

Behaviour:
- Reset (sync, highest priority): State=IDLE; Cpu_en=0, Cpu_restart=0, Halted=0, Cycle_count=0; divider=0; synchronisers cleared.
- Buttons: each passes a 2-flop synchroniser plus an edge register. An event is a 1-cycle internal pulse asserted 3 Clk edges after the button is first sampled high. Holding a button gives exactly one event.
- IDLE: Cpu_en=0. A restart event moves to RESTART.
- RESTART: Cpu_restart=1 for exactly RST_HOLD cycles. Cycle_count cleared on entry and divider cleared. Then go to RUN; Cpu_restart=0 from the first RUN cycle.
- RUN, Mode=0: divider counts 0..Div_ratio. On reaching Div_ratio it reloads 0 and raises tick. Div_ratio=0 gives a tick every cycle. Div_ratio is sampled on each compare, so changes take effect mid-count.
- RUN, Mode=1: the divider is idle and a step event raises tick.
- On tick in RUN, checks in priority order:
  - Bp_en && PC==Bp_addr: go to HALT with no pulse.
  - Max_cycles!=0 && Cycle_count==Max_cycles: go to HALT with no pulse.
  - Otherwise Cpu_en=1 for that cycle and Cycle_count+1, saturating at all-ones.
- HALT: Halted=1, Cpu_en=0.
  - A step event issues one Cpu_en pulse without the breakpoint check (steps off the breakpoint), increments Cycle_count, and returns to RUN.
  - A step event while the budget is exhausted stays in HALT with no pulse.
- Restart event in RUN or HALT: go to RESTART immediately. It beats a coincident tick or step; no Cpu_en pulse that cycle.
- Coincident restart and step events: restart wins and the step is discarded.
- Cpu_en is never high while Cpu_restart is high. Cpu_en is never high on two consecutive cycles unless Mode=0 and Div_ratio=0.
- All outputs are registered; State encodes as listed.

Test Plan:
1. Reset=1 for 2 cycles, then Restart_btn high → event at edge 3; Cpu_restart high for exactly 4 cycles; State 00→01→10; Cycle_count=0.
2. Mode=0, Div_ratio=3, Max_cycles=0, Bp_en=0 → Cpu_en pulses every 4th Clk; after 40 cycles of RUN, Cycle_count=10.
3. Mode=0, Div_ratio=0, Bp_en=1, Bp_addr=16'h0006, PC driven as Cycle_count*2 → Halted=1 once PC=6 and Cycle_count=3. A Step_btn edge then gives one Cpu_en pulse, Cycle_count=4, and RUN resumes.
4. Mode=1 with Step_btn toggled 5 times, each held 10 cycles → exactly 5 Cpu_en pulses, 3 cycles after each rise; Cycle_count=5.
5. Max_cycles=20, Div_ratio=1 → HALT with Cycle_count=20 and no further pulses; a Step_btn edge stays in HALT.
6. Restart_btn pressed mid-RUN coincident with a tick, then Reset asserted during RESTART → no Cpu_en pulse, Cycle_count=0, State=00 on the cycle after Reset.
